axi_mm_reg_sink: RTL and testbench

//  Responder (sink) end of the if_axi_mm memory-mapped link: register bank answering wr/rd

---
 rtl/axi_mm_reg_sink.sv | 152 +++++++++++++++
 tb/tb_axi_mm_reg_sink.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mm_reg_sink.sv
// axi_mm_reg_sink: responder end of the if_axi_mm memory-mapped link.
// Register bank with NUM_RW read/write config registers followed by NUM_RO
// read-only status words. Writes complete in one cycle; reads answer RD_LAT
// cycles after acceptance with o_wait_rq held high until the response cycle ends.
// Optional feature macro: AXI_MM_REG_SINK_WR_PULSE_EN enables per-register
// write strobes on o_wr_pulse; without it o_wr_pulse is constant zero.

module axi_mm_reg_sink #(
   parameter int                D_BITS     = 64,
   parameter int                A_BITS     = 8,
   parameter int                NUM_RW     = 8,
   parameter int                NUM_RO     = 4,
   parameter int                RD_LAT     = 2,
   parameter logic [D_BITS-1:0] RD_DEFAULT = 'hDEAD_BEEF
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic [A_BITS-1:0]        i_addr,
   input  logic [D_BITS-1:0]        i_wr_dat,
   input  logic                     i_wr,
   input  logic                     i_rd,
   output logic [D_BITS-1:0]        o_rd_dat,
   output logic                     o_rd_dat_val,
   output logic                     o_wait_rq,
   input  logic [NUM_RO*D_BITS-1:0] i_ro,
   output logic [NUM_RW*D_BITS-1:0] o_rw,
   output logic [NUM_RW-1:0]        o_wr_pulse
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      RESP    = 2'd2
   } state_t;

   // RD_WAIT lasts RD_LAT-1 cycles; the counter runs 0..LAST_CNT inside it
   localparam int LAST_CNT = (RD_LAT >= 2) ? RD_LAT - 2 : 0;
   localparam int CNT_W    = (LAST_CNT > 0) ? $clog2(LAST_CNT + 1) : 1;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [D_BITS-1:0] rd_hold;
   logic [D_BITS-1:0] rd_sel;
   logic [D_BITS-1:0] rw_q [NUM_RW];
   logic              wr_acc;
   logic              rd_acc;

   // A write wins over a simultaneous read; the read is simply dropped
   assign wr_acc = (state == IDLE) && i_wr;
   assign rd_acc = (state == IDLE) && i_rd && !i_wr;

   // Address decode for reads: RW bank, then RO words, otherwise the default pattern
   always_comb begin
      rd_sel = RD_DEFAULT;
      for (int k = 0; k < NUM_RW; k++) begin
         if (i_addr == A_BITS'(k)) begin
            rd_sel = rw_q[k];
         end
      end
      for (int k = 0; k < NUM_RO; k++) begin
         if (i_addr == A_BITS'(NUM_RW + k)) begin
            rd_sel = i_ro[k*D_BITS +: D_BITS];
         end
      end
   end

   // Read handshake FSM; data is frozen at the accept edge and released in RESP
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state        <= IDLE;
         cnt          <= '0;
         rd_hold      <= '0;
         o_rd_dat     <= '0;
         o_rd_dat_val <= 1'b0;
         o_wait_rq    <= 1'b0;
      end else begin
         o_rd_dat_val <= 1'b0;
         case (state)
            IDLE: begin
               if (rd_acc) begin
                  o_wait_rq <= 1'b1;
                  if (RD_LAT == 1) begin
                     state        <= RESP;
                     o_rd_dat     <= rd_sel;
                     o_rd_dat_val <= 1'b1;
                  end else begin
                     state   <= RD_WAIT;
                     rd_hold <= rd_sel;
                     cnt     <= '0;
                  end
               end
            end
            RD_WAIT: begin
               if (cnt == CNT_W'(LAST_CNT)) begin
                  state        <= RESP;
                  o_rd_dat     <= rd_hold;
                  o_rd_dat_val <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RESP: begin
               state     <= IDLE;
               o_wait_rq <= 1'b0;
            end
            default: begin
               state     <= IDLE;
               o_wait_rq <= 1'b0;
            end
         endcase
      end
   end

   // RW register bank; writes to RO or unmapped addresses match no register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int k = 0; k < NUM_RW; k++) begin
            rw_q[k] <= '0;
         end
      end else if (wr_acc) begin
         for (int k = 0; k < NUM_RW; k++) begin
            if (i_addr == A_BITS'(k)) begin
               rw_q[k] <= i_wr_dat;
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_RW; g++) begin : g_pack
      assign o_rw[g*D_BITS +: D_BITS] = rw_q[g];
   end

`ifdef AXI_MM_REG_SINK_WR_PULSE_EN
   logic [NUM_RW-1:0] wr_pulse_q;

   // One-cycle strobe aligned with the register update, even for identical data
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_pulse_q <= '0;
      end else begin
         for (int k = 0; k < NUM_RW; k++) begin
            wr_pulse_q[k] <= wr_acc && (i_addr == A_BITS'(k));
         end
      end
   end

   assign o_wr_pulse = wr_pulse_q;
`else
   assign o_wr_pulse = '0;
`endif

endmodule

// File: tb/tb_axi_mm_reg_sink.sv
// tb_axi_mm_reg_sink: directed bench for axi_mm_reg_sink with default parameters.
// A per-cycle vector table covers writes, reads, RO/unmapped decoding and
// boundaries; hand-written sequences cover stalls, RO sampling and reset mid-read.

module tb_axi_mm_reg_sink;

   localparam int D_BITS = 64;
   localparam int A_BITS = 8;
   localparam int NUM_RW = 8;
   localparam int NUM_RO = 4;
   localparam int RD_LAT = 2;
   localparam logic [63:0] DEF = 64'h0000_0000_DEAD_BEEF;

`ifdef AXI_MM_REG_SINK_WR_PULSE_EN
   localparam bit PULSE_ON = 1'b1;
`else
   localparam bit PULSE_ON = 1'b0;
`endif

   logic                     i_clk;
   logic                     i_rst;
   logic [A_BITS-1:0]        i_addr;
   logic [D_BITS-1:0]        i_wr_dat;
   logic                     i_wr;
   logic                     i_rd;
   logic [D_BITS-1:0]        o_rd_dat;
   logic                     o_rd_dat_val;
   logic                     o_wait_rq;
   logic [NUM_RO*D_BITS-1:0] i_ro;
   logic [NUM_RW*D_BITS-1:0] o_rw;
   logic [NUM_RW-1:0]        o_wr_pulse;

   int checks;
   int errors;

   logic [63:0] shadow [NUM_RW];

   typedef struct {
      logic        wr;
      logic        rd;
      logic [7:0]  addr;
      logic [63:0] wdat;
      logic        exp_wait;
      logic        exp_val;
      logic [63:0] exp_dat;
      logic        upd;
      int          upd_idx;
      logic [63:0] upd_val;
      logic [7:0]  exp_pulse;
   } vec_t;

   vec_t vecs[$];

   axi_mm_reg_sink #(
      .D_BITS     (D_BITS),
      .A_BITS     (A_BITS),
      .NUM_RW     (NUM_RW),
      .NUM_RO     (NUM_RO),
      .RD_LAT     (RD_LAT),
      .RD_DEFAULT (DEF)
   ) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_addr       (i_addr),
      .i_wr_dat     (i_wr_dat),
      .i_wr         (i_wr),
      .i_rd         (i_rd),
      .o_rd_dat     (o_rd_dat),
      .o_rd_dat_val (o_rd_dat_val),
      .o_wait_rq    (o_wait_rq),
      .i_ro         (i_ro),
      .o_rw         (o_rw),
      .o_wr_pulse   (o_wr_pulse)
   );

   // Free-running 100 MHz clock
   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   function automatic vec_t mk(logic wr, logic rd, logic [7:0] addr, logic [63:0] wdat,
                               logic ew, logic ev, logic [63:0] ed,
                               logic upd, int idx, logic [63:0] uv, logic [7:0] ep);
      vec_t v;
      v.wr = wr; v.rd = rd; v.addr = addr; v.wdat = wdat;
      v.exp_wait = ew; v.exp_val = ev; v.exp_dat = ed;
      v.upd = upd; v.upd_idx = idx; v.upd_val = uv; v.exp_pulse = ep;
      return v;
   endfunction

   function automatic logic [NUM_RW*D_BITS-1:0] packed_shadow();
      logic [NUM_RW*D_BITS-1:0] p;
      for (int k = 0; k < NUM_RW; k++) p[k*D_BITS +: D_BITS] = shadow[k];
      return p;
   endfunction

   // Drive one request for one clock, then land 1 ns after the edge for sampling
   task automatic applyStimulus(input logic wr, input logic rd, input logic [7:0] addr,
                                input logic [63:0] wdat);
      i_wr     = wr;
      i_rd     = rd;
      i_addr   = addr;
      i_wr_dat = wdat;
      @(posedge i_clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [511:0] act,
                              input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic checkPulse(input string name, input logic [7:0] exp_on);
      logic [7:0] exp;
      exp = PULSE_ON ? exp_on : 8'h00;
      checkOutput(name, 512'(o_wr_pulse), 512'(exp));
   endtask

   initial begin
      // Cycle-by-cycle vector table (expected values are after the clock edge)
      vecs.push_back(mk(1,0,8'd3,  64'h1234, 0,0,64'h0,    1,3,64'h1234, 8'h08));
      vecs.push_back(mk(0,1,8'd3,  64'h0,    1,0,64'h0,    0,0,64'h0,    8'h00));
      vecs.push_back(mk(0,0,8'd0,  64'h0,    1,1,64'h1234, 0,0,64'h0,    8'h00));
      vecs.push_back(mk(0,0,8'd0,  64'h0,    0,0,64'h1234, 0,0,64'h0,    8'h00));
      vecs.push_back(mk(0,1,8'd9,  64'h0,    1,0,64'h1234, 0,0,64'h0,    8'h00));
      vecs.push_back(mk(0,0,8'd0,  64'h0,    1,1,64'hA5A5, 0,0,64'h0,    8'h00));
      vecs.push_back(mk(0,0,8'd0,  64'h0,    0,0,64'hA5A5, 0,0,64'h0,    8'h00));
      vecs.push_back(mk(1,0,8'd9,  64'hFFFF, 0,0,64'hA5A5, 0,0,64'h0,    8'h00));
      vecs.push_back(mk(0,1,8'd9,  64'h0,    1,0,64'hA5A5, 0,0,64'h0,    8'h00));
      vecs.push_back(mk(0,0,8'd0,  64'h0,    1,1,64'hA5A5, 0,0,64'h0,    8'h00));
      vecs.push_back(mk(0,0,8'd0,  64'h0,    0,0,64'hA5A5, 0,0,64'h0,    8'h00));
      vecs.push_back(mk(0,1,8'hF0, 64'h0,    1,0,64'hA5A5, 0,0,64'h0,    8'h00));
      vecs.push_back(mk(0,0,8'd0,  64'h0,    1,1,DEF,      0,0,64'h0,    8'h00));
      vecs.push_back(mk(0,0,8'd0,  64'h0,    0,0,DEF,      0,0,64'h0,    8'h00));
      vecs.push_back(mk(1,0,8'hF0, 64'h5555, 0,0,DEF,      0,0,64'h0,    8'h00));
      vecs.push_back(mk(1,1,8'd0,  64'hAAAA, 0,0,DEF,      1,0,64'hAAAA, 8'h01));
      vecs.push_back(mk(0,0,8'd0,  64'h0,    0,0,DEF,      0,0,64'h0,    8'h00));
      vecs.push_back(mk(1,0,8'd7,  64'h77,   0,0,DEF,      1,7,64'h77,   8'h80));
      vecs.push_back(mk(1,0,8'd8,  64'h99,   0,0,DEF,      0,0,64'h0,    8'h00));
      vecs.push_back(mk(0,1,8'd7,  64'h0,    1,0,DEF,      0,0,64'h0,    8'h00));
      vecs.push_back(mk(0,1,8'd7,  64'h0,    1,1,64'h77,   0,0,64'h0,    8'h00));
      vecs.push_back(mk(0,0,8'd0,  64'h0,    0,0,64'h77,   0,0,64'h0,    8'h00));
      vecs.push_back(mk(0,1,8'd11, 64'h0,    1,0,64'h77,   0,0,64'h0,    8'h00));
      vecs.push_back(mk(0,0,8'd0,  64'h0,    1,1,64'h3333, 0,0,64'h0,    8'h00));
      vecs.push_back(mk(0,0,8'd0,  64'h0,    0,0,64'h3333, 0,0,64'h0,    8'h00));
      vecs.push_back(mk(0,1,8'd12, 64'h0,    1,0,64'h3333, 0,0,64'h0,    8'h00));
      vecs.push_back(mk(0,0,8'd0,  64'h0,    1,1,DEF,      0,0,64'h0,    8'h00));
      vecs.push_back(mk(0,0,8'd0,  64'h0,    0,0,DEF,      0,0,64'h0,    8'h00));

      checks = 0;
      errors = 0;
      for (int k = 0; k < NUM_RW; k++) shadow[k] = 64'h0;
      i_wr     = 1'b0;
      i_rd     = 1'b0;
      i_addr   = '0;
      i_wr_dat = '0;
      i_ro     = {64'h3333, 64'h2222, 64'hA5A5, 64'h1111};
      i_rst    = 1'b1;
      repeat (3) @(posedge i_clk);
      #1;
      i_rst = 1'b0;

      // Reset state
      checkOutput("reset_rw",   512'(o_rw),         512'(packed_shadow()));
      checkOutput("reset_wait", 512'(o_wait_rq),    512'(1'b0));
      checkOutput("reset_val",  512'(o_rd_dat_val), 512'(1'b0));
      checkOutput("reset_dat",  512'(o_rd_dat),     512'(64'h0));
      checkPulse("reset_pulse", 8'h00);

      // Table-driven vectors
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdat);
         if (vecs[i].upd) shadow[vecs[i].upd_idx] = vecs[i].upd_val;
         checkOutput($sformatf("vec%0d_wait", i), 512'(o_wait_rq),    512'(vecs[i].exp_wait));
         checkOutput($sformatf("vec%0d_val", i),  512'(o_rd_dat_val), 512'(vecs[i].exp_val));
         checkOutput($sformatf("vec%0d_dat", i),  512'(o_rd_dat),     512'(vecs[i].exp_dat));
         checkOutput($sformatf("vec%0d_rw", i),   512'(o_rw),         512'(packed_shadow()));
         checkPulse($sformatf("vec%0d_pulse", i), vecs[i].exp_pulse);
      end

      // RO word is captured at the accept edge, not at the response edge
      applyStimulus(0, 1, 8'd8, 64'h0);
      i_ro[63:0] = 64'h9999;
      applyStimulus(0, 0, 8'd0, 64'h0);
      checkOutput("ro_sample_val", 512'(o_rd_dat_val), 512'(1'b1));
      checkOutput("ro_sample_dat", 512'(o_rd_dat),     512'(64'h1111));
      applyStimulus(0, 0, 8'd0, 64'h0);
      i_ro[63:0] = 64'h1111;

      // Write to addr 2 held across a read of addr 0 is stalled until after RESP
      applyStimulus(0, 1, 8'd0, 64'h0);
      checkOutput("stall_acc_wait", 512'(o_wait_rq), 512'(1'b1));
      applyStimulus(1, 0, 8'd2, 64'h22);
      checkOutput("stall_resp_val", 512'(o_rd_dat_val), 512'(1'b1));
      checkOutput("stall_resp_dat", 512'(o_rd_dat),     512'(64'hAAAA));
      checkOutput("stall_resp_wait", 512'(o_wait_rq),   512'(1'b1));
      checkOutput("stall_rw_a", 512'(o_rw), 512'(packed_shadow()));
      checkPulse("stall_pulse_a", 8'h00);
      applyStimulus(1, 0, 8'd2, 64'h22);
      checkOutput("stall_idle_wait", 512'(o_wait_rq),  512'(1'b0));
      checkOutput("stall_idle_val", 512'(o_rd_dat_val), 512'(1'b0));
      checkOutput("stall_rw_b", 512'(o_rw), 512'(packed_shadow()));
      checkPulse("stall_pulse_b", 8'h00);
      applyStimulus(1, 0, 8'd2, 64'h22);
      shadow[2] = 64'h22;
      checkOutput("stall_rw_land", 512'(o_rw), 512'(packed_shadow()));
      checkPulse("stall_pulse_land", 8'h04);
      applyStimulus(0, 0, 8'd0, 64'h0);
      checkPulse("stall_pulse_off", 8'h00);
      checkOutput("stall_rw_after", 512'(o_rw), 512'(packed_shadow()));

      // Reset pulse while a read sits in RD_WAIT discards it
      applyStimulus(0, 1, 8'd3, 64'h0);
      checkOutput("rst_mid_wait_pre", 512'(o_wait_rq), 512'(1'b1));
      i_rd  = 1'b0;
      i_rst = 1'b1;
      #2;
      i_rst = 1'b0;
      for (int k = 0; k < NUM_RW; k++) shadow[k] = 64'h0;
      checkOutput("rst_mid_rw",   512'(o_rw),         512'(packed_shadow()));
      checkOutput("rst_mid_wait", 512'(o_wait_rq),    512'(1'b0));
      checkOutput("rst_mid_val",  512'(o_rd_dat_val), 512'(1'b0));
      for (int c = 0; c < 3; c++) begin
         applyStimulus(0, 0, 8'd0, 64'h0);
         checkOutput($sformatf("rst_no_resp%0d", c), 512'(o_rd_dat_val), 512'(1'b0));
      end

      // Next read after the reset completes normally
      applyStimulus(1, 0, 8'd3, 64'hBEEF);
      shadow[3] = 64'hBEEF;
      applyStimulus(0, 1, 8'd3, 64'h0);
      checkOutput("post_rst_wait1", 512'(o_wait_rq),    512'(1'b1));
      checkOutput("post_rst_val0",  512'(o_rd_dat_val), 512'(1'b0));
      applyStimulus(0, 0, 8'd0, 64'h0);
      checkOutput("post_rst_val",   512'(o_rd_dat_val), 512'(1'b1));
      checkOutput("post_rst_dat",   512'(o_rd_dat),     512'(64'hBEEF));
      applyStimulus(0, 0, 8'd0, 64'h0);
      checkOutput("post_rst_idle",  512'(o_wait_rq),    512'(1'b0));
      checkOutput("post_rst_rw",    512'(o_rw),         512'(packed_shadow()));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
